// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests and drives the IF/ID latch into DECODE.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch_count / stall_count outputs.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchAddr,
    input  logic        HLT,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic [15:0] instruction,
    output logic [15:0] PC_plus_2,
    output logic        if_valid,
    output logic [15:0] PC,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [2:0] {
        FETCH,
        SQUASH,
        BUFFER,
        DRAIN_HALT,
        HALTED
    } state_t;

    state_t      state;
    logic [15:0] buf_word;
    logic [15:0] pc_next2;
    logic        do_halt;
    logic        do_branch;

    assign pc_next2  = PC + 16'd2;
    assign do_halt   = if_valid & HLT & ~stall;
    assign do_branch = if_valid & BranchTaken & ~stall;

    // imem_addr is its own register: during SQUASH/DRAIN_HALT it must keep the
    // outstanding address while PC already holds the redirect/halt target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            PC          <= RESET_PC;
            imem_addr   <= RESET_PC;
            imem_req    <= 1'b1;
            instruction <= '0;
            PC_plus_2   <= '0;
            if_valid    <= 1'b0;
            halted      <= 1'b0;
            buf_word    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (do_halt) begin
                        PC          <= PC_plus_2;
                        if_valid    <= 1'b0;
                        instruction <= '0;
                        halted      <= 1'b1;
                        if (imem_valid) begin
                            state    <= HALTED;
                            imem_req <= 1'b0;
                        end else begin
                            state <= DRAIN_HALT;
                        end
                    end else if (do_branch) begin
                        PC          <= BranchAddr;
                        if_valid    <= 1'b0;
                        instruction <= '0;
                        if (imem_valid) begin
                            imem_addr <= BranchAddr;
                        end else begin
                            state <= SQUASH;
                        end
                    end else if (imem_valid) begin
                        PC        <= pc_next2;
                        imem_addr <= pc_next2;
                        if (stall) begin
                            buf_word <= imem_rdata;
                            state    <= BUFFER;
                            imem_req <= 1'b0;
                        end else begin
                            instruction <= imem_rdata;
                            PC_plus_2   <= pc_next2;
                            if_valid    <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end

                SQUASH: begin
                    if (imem_valid) begin
                        imem_addr <= PC;
                        state     <= FETCH;
                    end
                end

                // PC already points past the buffered word, so it doubles as its PC_plus_2.
                BUFFER: begin
                    if (!stall) begin
                        if (do_halt) begin
                            PC          <= PC_plus_2;
                            if_valid    <= 1'b0;
                            instruction <= '0;
                            halted      <= 1'b1;
                            state       <= HALTED;
                        end else if (do_branch) begin
                            PC          <= BranchAddr;
                            imem_addr   <= BranchAddr;
                            if_valid    <= 1'b0;
                            instruction <= '0;
                            imem_req    <= 1'b1;
                            state       <= FETCH;
                        end else begin
                            instruction <= buf_word;
                            PC_plus_2   <= PC;
                            if_valid    <= 1'b1;
                            imem_req    <= 1'b1;
                            state       <= FETCH;
                        end
                    end
                end

                DRAIN_HALT: begin
                    if (imem_valid) begin
                        imem_req <= 1'b0;
                        state    <= HALTED;
                    end
                end

                HALTED: begin
                end

                default: state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic load_ifid;
    logic stall_seen;

    assign load_ifid  = ~stall & ~do_halt & ~do_branch &
                        (((state == FETCH) & imem_valid) | (state == BUFFER));
    assign stall_seen = stall & ((state == FETCH) | (state == BUFFER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (load_ifid && fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (stall_seen && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Random-stimulus scoreboard bench for fetch_stage: a program-order model predicts every word DECODE consumes.
module tb_fetch_stage;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [15:0] BranchAddr = '0;
    logic        HLT = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic [15:0] instruction;
    logic [15:0] PC_plus_2;
    logic        if_valid;
    logic [15:0] PC;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .BranchTaken (BranchTaken),
        .BranchAddr  (BranchAddr),
        .HLT         (HLT),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instruction (instruction),
        .PC_plus_2   (PC_plus_2),
        .if_valid    (if_valid),
        .PC          (PC),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int          total_cnt = 0;
    int          pass_cnt = 0;
    int          pop_cnt = 0;
    int          lat_max = 0;
    logic [31:0] exp_q[$];
    logic [15:0] cur_addr;
    logic        model_halted = 1'b0;
    logic [15:0] exp_halt_pc;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h0412;
        return {a[6:0], a[15:7]} ^ 16'hB7E1;
    endfunction

    // Instruction memory: one outstanding request, random 0..lat_max cycle latency.
    initial begin
        logic        pending;
        int          cnt;
        logic [15:0] pend_addr;
        pending = 1'b0;
        cnt = 0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0;
                imem_valid = 1'b0;
            end else begin
                if (imem_valid) begin
                    pending = 1'b0;
                    imem_valid = 1'b0;
                end else if (pending) begin
                    check("imem_hold", {imem_req, imem_addr}, {1'b1, pend_addr});
                    if (cnt > 0) cnt--;
                end
                if (!pending && imem_req) begin
                    pending = 1'b1;
                    pend_addr = imem_addr;
                    cnt = $urandom_range(lat_max, 0);
                end
                if (pending && cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(pend_addr);
                end
            end
        end
    end

    // Monitor: every cycle DECODE consumes IF/ID must match the next predicted word.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && if_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL ifid_extra: got %0h expected none", {instruction, PC_plus_2});
                end else begin
                    e = exp_q.pop_front();
                    pop_cnt++;
                    check("ifid_word", {instruction, PC_plus_2}, e);
                end
            end
        end
    end

    task automatic push_expected(input logic [15:0] a);
        exp_q.push_back({mem_word(a), 16'(a + 16'd2)});
    endtask

    task automatic step(input logic s, input logic bt, input logic [15:0] ba, input logic h);
        @(posedge clk);
        #2;
        stall = s;
        BranchTaken = bt;
        BranchAddr = ba;
        HLT = h;
        if (rst_n && if_valid && !s && !model_halted) begin
            if (h) begin
                model_halted = 1'b1;
                exp_halt_pc = cur_addr + 16'd2;
            end else begin
                cur_addr = bt ? ba : cur_addr + 16'd2;
                push_expected(cur_addr);
            end
        end
    endtask

    task automatic run_random(input int n);
        logic        s;
        logic        bt;
        logic [15:0] ba;
        for (int i = 0; i < n; i++) begin
            s  = ($urandom % 4) == 0;
            bt = ($urandom % 6) == 0;
            ba = (($urandom % 4) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
            step(s, bt, ba, 1'b0);
        end
    endtask

    task automatic check_reset_state(input string name);
        check(name, {PC, instruction, PC_plus_2, if_valid, halted},
              {RST_PC, 16'h0000, 16'h0000, 1'b0, 1'b0});
    endtask

    initial begin
        int pops_before;
        int i;

        repeat (2) @(posedge clk);
        #2;
        check_reset_state("reset_state");
        cur_addr = RST_PC;
        push_expected(cur_addr);
        rst_n = 1'b1;

        @(negedge clk);
        check("first_req", {imem_req, imem_addr}, {1'b1, RST_PC});
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        check("first_capture", {instruction, PC_plus_2, if_valid, PC},
              {16'h0412, 16'h0002, 1'b1, 16'h0002});

        lat_max = 3;
        run_random(1500);

        // Halt with a simultaneous branch: halt must win.
        i = 0;
        while (!model_halted && i < 50) begin
            step(1'b0, 1'b1, 16'h1234, 1'b1);
            i++;
        end
        check("halt_issued", model_halted, 1'b1);
        i = 0;
        do begin
            step(1'($urandom % 2), 1'($urandom % 2), 16'h2222, 1'b0);
            i++;
        end while (imem_req && i < 20);
        check("halt_drained", {imem_req, halted, PC}, {1'b0, 1'b1, exp_halt_pc});
        for (int k = 0; k < 20; k++) begin
            step(1'($urandom % 2), 1'($urandom % 2), 16'h3332, 1'($urandom % 2));
            check("halted_hold", {if_valid, halted, imem_req, PC}, {1'b0, 1'b1, 1'b0, exp_halt_pc});
        end

        @(posedge clk);
        #2;
        stall = 1'b0;
        BranchTaken = 1'b0;
        HLT = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_midrun");
        exp_q.delete();
        model_halted = 1'b0;
        cur_addr = RST_PC;
        push_expected(cur_addr);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        pops_before = pop_cnt;
        run_random(500);
        check("fetch_resumed", (pop_cnt - pops_before) >= 50, 1'b1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
